// File: rtl/cond_logic_if.sv
// Decoder/ALU-side signal bundle for the conditional-execution unit.
// slave = cond_logic itself, master = the driving datapath (or bench).
interface cond_logic_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       MStart;
  logic       MDone;
  logic [1:0] MFlags;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       MRegWrite;
  logic       Busy;
  logic       CondEx;
  logic       Carry;
  logic [3:0] Flags;

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, MStart, MDone, MFlags,
    output PCSrc, RegWrite, MemWrite, MRegWrite, Busy, CondEx, Carry, Flags
  );

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, MStart, MDone, MFlags,
    input  PCSrc, RegWrite, MemWrite, MRegWrite, Busy, CondEx, Carry, Flags
  );
endinterface

// File: rtl/cond_logic.sv
// NZCV flag register, condition evaluation, write gating and the
// IDLE/BUSY sequencer for multi-cycle (MUL/DIV) operations.
module cond_logic (
  input  logic        CLK,
  input  logic        RESETn,
  cond_logic_if.slave bus
);
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t     r_state;
  logic [3:0] r_flags;
  logic       r_pend_nz;
  logic       r_pend_rw;

  logic w_n, w_z, w_c, w_v;
  logic w_condex;
  logic w_idle;

  assign {w_n, w_z, w_c, w_v} = r_flags;
  assign w_idle = (r_state == S_IDLE);

  always_comb begin
    w_condex = 1'b0;
    case (bus.Cond)
      4'b0000: w_condex = w_z;
      4'b0001: w_condex = ~w_z;
      4'b0010: w_condex = w_c;
      4'b0011: w_condex = ~w_c;
      4'b0100: w_condex = w_n;
      4'b0101: w_condex = ~w_n;
      4'b0110: w_condex = w_v;
      4'b0111: w_condex = ~w_v;
      4'b1000: w_condex = w_c & ~w_z;
      4'b1001: w_condex = ~w_c | w_z;
      4'b1010: w_condex = ~(w_n ^ w_v);
      4'b1011: w_condex = w_n ^ w_v;
      4'b1100: w_condex = ~w_z & ~(w_n ^ w_v);
      4'b1101: w_condex = w_z | (w_n ^ w_v);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  // Flags come from the stored register only: an instruction never sees its own update.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state   <= S_IDLE;
      r_flags   <= 4'b0000;
      r_pend_nz <= 1'b0;
      r_pend_rw <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.MStart) begin
            if (w_condex) begin
              r_state   <= S_BUSY;
              r_pend_nz <= bus.FlagW[1];
              r_pend_rw <= bus.RegW & ~bus.NoWrite;
            end
          end else if (w_condex) begin
            if (bus.FlagW[1]) r_flags[3:2] <= bus.ALUFlags[3:2];
            if (bus.FlagW[0]) r_flags[1:0] <= bus.ALUFlags[1:0];
          end
        end
        S_BUSY: begin
          if (bus.MDone) begin
            r_state   <= S_IDLE;
            if (r_pend_nz) r_flags[3:2] <= bus.MFlags;
            r_pend_nz <= 1'b0;
            r_pend_rw <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.CondEx    = w_condex;
  assign bus.PCSrc     = w_idle & bus.PCS & w_condex;
  assign bus.RegWrite  = w_idle & bus.RegW & w_condex & ~bus.NoWrite & ~bus.MStart;
  assign bus.MemWrite  = w_idle & bus.MemW & w_condex;
  assign bus.MRegWrite = ~w_idle & bus.MDone & r_pend_rw;
  assign bus.Busy      = ~w_idle;
  assign bus.Carry     = w_c;
  assign bus.Flags     = r_flags;
endmodule
